// File: rtl/activation_cache.sv
// rtl/activation_cache.sv - ring-buffer tap feeder for a 4-tap dilated causal conv1d; optional ACTIVATION_CACHE_PRIMED_EN
module activation_cache #(
    parameter int W        = 16,
    parameter int D        = 4,
    parameter int DILATION = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [D*W-1:0] packed_in,
    input  logic           in_v,
    output logic           in_ready,
    output logic [D*W-1:0] packed_a0,
    output logic [D*W-1:0] packed_a1,
    output logic [D*W-1:0] packed_a2,
    output logic [D*W-1:0] packed_a3,
    output logic           out_v
`ifdef ACTIVATION_CACHE_PRIMED_EN
    ,
    output logic           primed
`endif
);
    localparam int DEPTH = 3 * DILATION + 1;
    localparam int PW    = $clog2(DEPTH);

    typedef enum logic [1:0] {CLEAR, IDLE, READ, OUTPUT} state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  clr_idx_q, clr_idx_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  head_q, head_d;
    logic [1:0]     tap_q, tap_d;

    logic [D*W-1:0] mem [DEPTH];
    logic           mem_we;
    logic [PW-1:0]  mem_waddr;
    logic [D*W-1:0] mem_wdata;

    logic           rd_en;
    logic [PW:0]    rd_off;
    logic [PW:0]    rd_diff;
    logic [PW-1:0]  rd_addr;

    logic [D*W-1:0] a_q [4];

    // State and pointer registers; reset discards history and restarts the zero fill
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            wr_ptr_q  <= '0;
            head_q    <= '0;
            tap_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            wr_ptr_q  <= wr_ptr_d;
            head_q    <= head_d;
            tap_q     <= tap_d;
        end
    end

    // Next-state, handshake outputs and the single memory write port
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        wr_ptr_d  = wr_ptr_q;
        head_d    = head_q;
        tap_d     = tap_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;
        mem_wdata = packed_in;
        rd_en     = 1'b0;
        in_ready  = 1'b0;
        out_v     = 1'b0;
        unique case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                mem_wdata = '0;
                if (clr_idx_q == PW'(DEPTH - 1)) begin
                    clr_idx_d = '0;
                    state_d   = IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            IDLE, OUTPUT: begin
                in_ready = 1'b1;
                out_v    = (state_q == OUTPUT);
                if (in_v) begin
                    mem_we   = 1'b1;
                    head_d   = wr_ptr_q;
                    wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                    tap_d    = '0;
                    state_d  = READ;
                end
            end
            READ: begin
                rd_en = 1'b1;
                tap_d = tap_q + 1'b1;
                if (tap_q == 2'd3) begin
                    state_d = OUTPUT;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Tap address: head minus tap offset, wrapped by one conditional add instead of a divider
    always_comb begin
        unique case (tap_q)
            2'd0:    rd_off = (PW+1)'(3 * DILATION);
            2'd1:    rd_off = (PW+1)'(2 * DILATION);
            2'd2:    rd_off = (PW+1)'(DILATION);
            default: rd_off = '0;
        endcase
        rd_diff = {1'b0, head_q} - rd_off;
        rd_addr = rd_diff[PW] ? (rd_diff[PW-1:0] + PW'(DEPTH)) : rd_diff[PW-1:0];
    end

    // History storage without reset so it maps onto block RAM; zeroing is done by CLEAR
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read, one tap per cycle, steered into the matching output register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
            end
        end else if (rd_en) begin
            a_q[tap_q] <= mem[rd_addr];
        end
    end

    assign packed_a0 = a_q[0];
    assign packed_a1 = a_q[1];
    assign packed_a2 = a_q[2];
    assign packed_a3 = a_q[3];

`ifdef ACTIVATION_CACHE_PRIMED_EN
    logic [PW:0] fill_cnt_q;

    // Saturating count of accepted samples; primed once every tap holds a real sample
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt_q <= '0;
        end else if (in_v && in_ready && (fill_cnt_q != (PW+1)'(DEPTH))) begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
        end
    end

    assign primed = (fill_cnt_q == (PW+1)'(DEPTH));
`endif

endmodule

// File: tb/tb_activation_cache.sv
// tb/tb_activation_cache.sv - scoreboard bench for activation_cache (DILATION=2); optional ACTIVATION_CACHE_PRIMED_EN
module tb_activation_cache;
    localparam int W   = 16;
    localparam int D   = 4;
    localparam int DIL = 2;
    localparam int DW  = D * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_v = 1'b0;
    logic [DW-1:0] packed_in = '0;
    logic          in_ready;
    logic          out_v;
    logic [DW-1:0] a0, a1, a2, a3;
`ifdef ACTIVATION_CACHE_PRIMED_EN
    logic          primed;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [4*DW-1:0] exp_q [$];
    logic prev_v = 1'b0;

    int dil_tab [9][4] = '{
        '{0, 0, 0, 1}, '{0, 0, 0, 2}, '{0, 0, 1, 3}, '{0, 0, 2, 4}, '{0, 1, 3, 5},
        '{0, 2, 4, 6}, '{1, 3, 5, 7}, '{2, 4, 6, 8}, '{3, 5, 7, 9}
    };

    always #5 clk = ~clk;

    activation_cache #(.W(W), .D(D), .DILATION(DIL)) dut (
        .clk       (clk),
        .rst       (rst),
        .packed_in (packed_in),
        .in_v      (in_v),
        .in_ready  (in_ready),
        .packed_a0 (a0),
        .packed_a1 (a1),
        .packed_a2 (a2),
        .packed_a3 (a3),
        .out_v     (out_v)
`ifdef ACTIVATION_CACHE_PRIMED_EN
        ,
        .primed    (primed)
`endif
    );

    function automatic logic [DW-1:0] rep(input int k);
        return {4{16'(k)}};
    endfunction

    task automatic check(input string name, input logic [4*DW-1:0] act, input logic [4*DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each new output presentation is compared with the oldest expectation
    always @(negedge clk) begin
        if (out_v === 1'b1 && prev_v !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got out_v=1 expected no output");
            end else begin
                check("taps", {a0, a1, a2, a3}, exp_q.pop_front());
            end
        end
        prev_v <= out_v;
    end

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        in_v = 1'b0;
        @(negedge clk);
        check("rst_out_v", out_v, 0);
        check("rst_taps", {a0, a1, a2, a3}, 0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("clear_in_ready", in_ready, 0);
            @(negedge clk);
        end
        check("idle_in_ready", in_ready, 1);
        check("idle_out_v", out_v, 0);
`ifdef ACTIVATION_CACHE_PRIMED_EN
        check("primed_after_rst", primed, 0);
`endif
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [4*DW-1:0] exp);
        int t = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=%b expected 1", in_ready);
        end else begin
            packed_in = d;
            in_v      = 1'b1;
            exp_q.push_back(exp);
            @(negedge clk);
            in_v = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset/clear, then the first sample lands only in the newest tap
        do_reset();
        send(64'h1000_2000_3000_4000, {64'h0, 64'h0, 64'h0, 64'h1000_2000_3000_4000});
        drain();

        // Dilated taps across pointer and address wrap
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            send(rep(k), {rep(dil_tab[k-1][0]), rep(dil_tab[k-1][1]),
                          rep(dil_tab[k-1][2]), rep(dil_tab[k-1][3])});
`ifdef ACTIVATION_CACHE_PRIMED_EN
            check("primed", primed, (k >= 7));
`endif
        end
        drain();

        // Continuous in_v: accepted only on in_ready cycles, one output cycle per sample
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            packed_in = rep(c);
            in_v      = 1'b1;
            check("b2b_in_ready", in_ready, ((c - 1) % 5 == 0));
            check("b2b_out_v", out_v, ((c - 1) % 5 == 0) && (c > 1));
            case (c)
                1:  exp_q.push_back({64'h0, 64'h0, 64'h0, rep(1)});
                6:  exp_q.push_back({64'h0, 64'h0, 64'h0, rep(6)});
                11: exp_q.push_back({64'h0, 64'h0, rep(1), rep(11)});
                16: exp_q.push_back({64'h0, 64'h0, rep(6), rep(16)});
                default: ;
            endcase
        end
        @(negedge clk);
        in_v = 1'b0;
        drain();

        // Reset two cycles into a read: no output, history wiped
        @(negedge clk);
        check("mid_in_ready", in_ready, 1);
        packed_in = rep(170);
        in_v      = 1'b1;
        @(negedge clk);
        in_v = 1'b0;
        do_reset();
        send(rep(85), {64'h0, 64'h0, 64'h0, rep(85)});
        drain();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
